// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, reset vector, canonical NOP
// and the fetch FSM state encoding (also visible to the hazard unit for debug).
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
// can_accept tells the fetch FSM whether a new instruction may be written this cycle.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_d,
    input  logic            stall_d,
    input  logic            load_valid,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            can_accept
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    logic [31:0]     instr_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_plus4_r;
    logic            valid_r;

    assign instr_d    = instr_r;
    assign pc_d       = pc_r;
    assign pc_plus4_d = pc_plus4_r;
    assign valid_d    = valid_r;

    // A held valid instruction blocks loading; a bubble can always be overwritten.
    assign can_accept = !flush_d && (!stall_d || !valid_r);

    // IF/ID register update with flush > stall > load > bubble priority
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r    <= NOP_INSTR;
            pc_r       <= {XLEN{1'b0}};
            pc_plus4_r <= {XLEN{1'b0}};
            valid_r    <= 1'b0;
        end else if (flush_d) begin
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
        end else if (stall_d && valid_r) begin
            instr_r <= instr_r;
            valid_r <= valid_r;
        end else if (load_valid) begin
            instr_r    <= load_instr;
            pc_r       <= load_pc;
            pc_plus4_r <= load_pc + PC_STEP;
            valid_r    <= 1'b1;
        end else begin
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at a time,
// and feeds the IF/ID register through an optional one-entry hold buffer.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    input  logic            stall_d,
    input  logic            flush_d,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);

    localparam logic [XLEN-1:0] PC_STEP      = XLEN'(3'd4);
    localparam logic [XLEN-1:0] RESET_PC_ALN = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_t    state_r;
    fetch_state_t    state_nxt_s;
    logic [XLEN-1:0] pc_f_r;
    logic [XLEN-1:0] pc_f_seq_s;
    logic [XLEN-1:0] pc_f_nxt_s;
    logic [XLEN-1:0] pc_req_r;
    logic [XLEN-1:0] pc_req_nxt_s;
    logic            discard_r;
    logic            discard_nxt_s;
    logic [31:0]     hold_instr_r;
    logic [31:0]     hold_instr_nxt_s;
    logic [XLEN-1:0] hold_pc_r;
    logic [XLEN-1:0] hold_pc_nxt_s;
    logic            imem_req_r;
    logic [XLEN-1:0] imem_addr_r;

    logic [XLEN-1:0] target_aln_s;
    logic            redirect_s;
    logic            can_accept_s;
    logic            load_valid_s;
    logic [31:0]     load_instr_s;
    logic [XLEN-1:0] load_pc_s;

    assign imem_req     = imem_req_r;
    assign imem_addr    = imem_addr_r;
    assign target_aln_s = {pc_target_e[XLEN-1:2], 2'b00};
    assign redirect_s   = pc_src_e && (state_r != IDLE);
    // A redirect wins over the sequential +4 in every non-IDLE state.
    assign pc_f_nxt_s   = redirect_s ? target_aln_s : pc_f_seq_s;

    // Fetch FSM next-state, PC, discard flag and hold buffer
    always_comb begin
        state_nxt_s      = state_r;
        pc_f_seq_s       = pc_f_r;
        pc_req_nxt_s     = pc_req_r;
        discard_nxt_s    = discard_r;
        hold_instr_nxt_s = hold_instr_r;
        hold_pc_nxt_s    = hold_pc_r;
        load_valid_s     = 1'b0;
        load_instr_s     = imem_rdata;
        load_pc_s        = pc_req_r;
        case (state_r)
            IDLE: begin
                state_nxt_s = REQ;
            end
            REQ: begin
                if (imem_ready) begin
                    // The old address is accepted even when redirecting; its data is then dropped.
                    pc_req_nxt_s  = pc_f_r;
                    pc_f_seq_s    = pc_f_r + PC_STEP;
                    discard_nxt_s = pc_src_e;
                    state_nxt_s   = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (discard_r || pc_src_e) begin
                        discard_nxt_s = 1'b0;
                        state_nxt_s   = REQ;
                    end else if (can_accept_s) begin
                        load_valid_s = 1'b1;
                        state_nxt_s  = REQ;
                    end else begin
                        hold_instr_nxt_s = imem_rdata;
                        hold_pc_nxt_s    = pc_req_r;
                        state_nxt_s      = HOLD;
                    end
                end else if (pc_src_e) begin
                    discard_nxt_s = 1'b1;
                    state_nxt_s   = WAIT;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            HOLD: begin
                if (pc_src_e) begin
                    state_nxt_s = REQ;
                end else if (can_accept_s) begin
                    load_valid_s = 1'b1;
                    load_instr_s = hold_instr_r;
                    load_pc_s    = hold_pc_r;
                    state_nxt_s  = REQ;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Fetch state registers; request outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            pc_f_r       <= RESET_PC_ALN;
            pc_req_r     <= {XLEN{1'b0}};
            discard_r    <= 1'b0;
            hold_instr_r <= NOP_INSTR;
            hold_pc_r    <= {XLEN{1'b0}};
            imem_req_r   <= 1'b0;
            imem_addr_r  <= RESET_PC_ALN;
        end else begin
            state_r      <= state_nxt_s;
            pc_f_r       <= pc_f_nxt_s;
            pc_req_r     <= pc_req_nxt_s;
            discard_r    <= discard_nxt_s;
            hold_instr_r <= hold_instr_nxt_s;
            hold_pc_r    <= hold_pc_nxt_s;
            imem_req_r   <= (state_nxt_s == REQ);
            imem_addr_r  <= pc_f_nxt_s;
        end
    end

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .flush_d    (flush_d),
        .stall_d    (stall_d),
        .load_valid (load_valid_s),
        .load_instr (load_instr_s),
        .load_pc    (load_pc_s),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d),
        .can_accept (can_accept_s)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small instruction-memory model returns rdata=addr,
// and request addresses / decoded instructions are checked against scoreboard queues.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        stall_d;
    logic        flush_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic [31:0] addr_q[$];
    exp_t        instr_q[$];

    int          lat;
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard checks on the edge just taken, then the memory model.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic        held;
        logic        rst_pre;
        exp_t        e;
        acc     = imem_req && imem_ready;
        a       = imem_addr;
        held    = stall_d && valid_d;
        rst_pre = reset;
        @(posedge clk);
        #1;
        if (acc && !rst_pre) begin
            n_checks++;
            assert (addr_q.size() > 0) else begin
                n_fail++;
                $error("FAIL req_addr: observed request at %h expected none", a);
            end
            if (addr_q.size() > 0) chk("req_addr", a, addr_q.pop_front());
            pend      = 1'b1;
            pend_addr = a;
            cnt       = lat;
        end
        if (valid_d && !held && !rst_pre) begin
            n_checks++;
            assert (instr_q.size() > 0) else begin
                n_fail++;
                $error("FAIL decode_pop: observed instr at pc %h expected none", pc_d);
            end
            if (instr_q.size() > 0) begin
                e = instr_q.pop_front();
                chk("pc_d", pc_d, e.pc);
                chk("instr_d", instr_d, e.instr);
                chk("pc_plus4_d", pc_plus4_d, e.pc + 32'd4);
            end
        end
        if (reset) begin
            pend        = 1'b0;
            imem_rvalid = 1'b0;
        end else if (pend && cnt <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr;
            pend        = 1'b0;
        end else begin
            if (pend) cnt--;
            imem_rvalid = 1'b0;
        end
    endtask

    task automatic push_instr(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = pc;
        instr_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_instr"}, instr_d, NOP_INSTR);
        chk({tag, "_pc"}, pc_d, 32'h0);
        chk({tag, "_pc4"}, pc_plus4_d, 32'h0);
        chk({tag, "_valid"}, {31'd0, valid_d}, 32'd0);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_state"}, 32'(dut.state_r), 32'(IDLE));
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        pc_src_e = 1'b0; pc_target_e = 32'h0; stall_d = 1'b0; flush_d = 1'b0;
        lat = 1; pend = 1'b0; pend_addr = 32'h0; cnt = 0;
        repeat (3) tick();
        chk_reset_outputs("rst");

        // Straight-line fetch with 1-cycle memory
        reset = 1'b0;
        addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
        push_instr(32'h0); push_instr(32'h4); push_instr(32'h8);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t1_valid", {31'd0, valid_d}, (i == 2 || i == 4 || i == 6) ? 32'd1 : 32'd0);
        end

        // Stall while a response arrives: response parks in HOLD
        stall_d = 1'b1;
        addr_q.push_back(32'hC);
        tick();
        chk("t2_req_wait", {31'd0, imem_req}, 32'd0);
        tick();
        chk("t2_state", 32'(dut.state_r), 32'(HOLD));
        chk("t2_req_hold", {31'd0, imem_req}, 32'd0);
        chk("t2_pc_held", pc_d, 32'h8);
        chk("t2_valid_held", {31'd0, valid_d}, 32'd1);
        tick();
        chk("t2_state2", 32'(dut.state_r), 32'(HOLD));
        stall_d = 1'b0;
        push_instr(32'hC);
        tick();
        chk("t2_req_next", {31'd0, imem_req}, 32'd1);
        chk("t2_addr_next", imem_addr, 32'h10);

        // Redirect in WAIT, response two cycles after acceptance
        lat = 2;
        addr_q.push_back(32'h10);
        tick();
        pc_src_e = 1'b1; pc_target_e = 32'h103;
        tick();
        pc_src_e = 1'b0;
        chk("t3_valid_a", {31'd0, valid_d}, 32'd0);
        chk("t3_state", 32'(dut.state_r), 32'(WAIT));
        tick();
        chk("t3_valid_b", {31'd0, valid_d}, 32'd0);
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h100);
        lat = 1;
        addr_q.push_back(32'h100);
        push_instr(32'h100);
        tick(); tick();
        chk("t3_pc_arrive", pc_d, 32'h100);

        // Flush with stall and a simultaneous good response
        stall_d = 1'b1;
        addr_q.push_back(32'h104);
        tick();
        flush_d = 1'b1;
        tick();
        chk("t4_instr_nop", instr_d, NOP_INSTR);
        chk("t4_valid", {31'd0, valid_d}, 32'd0);
        chk("t4_pc_kept", pc_d, 32'h100);
        chk("t4_state", 32'(dut.state_r), 32'(HOLD));
        flush_d = 1'b0; stall_d = 1'b0;
        push_instr(32'h104);
        tick();

        // Redirect in REQ to the top word, then wrap to zero
        pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFF;
        addr_q.push_back(32'h108);
        tick();
        pc_src_e = 1'b0;
        addr_q.push_back(32'hFFFF_FFFC);
        push_instr(32'hFFFF_FFFC);
        tick();
        chk("t5_valid_drop", {31'd0, valid_d}, 32'd0);
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick(); tick();
        chk("t5_pc4_wrap", pc_plus4_d, 32'h0);
        chk("t5_addr_wrap", imem_addr, 32'h0);
        addr_q.push_back(32'h0);
        push_instr(32'h0);
        tick(); tick();

        // Reset while a request is outstanding, then a stale response
        addr_q.push_back(32'h4);
        tick();
        chk("t6_state_wait", 32'(dut.state_r), 32'(WAIT));
        reset = 1'b1;
        tick();
        chk_reset_outputs("t6_rst");
        tick();
        reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("t6_valid_a", {31'd0, valid_d}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("t6_valid_b", {31'd0, valid_d}, 32'd0);
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        chk("t6_addr_rstpc", imem_addr, 32'h0);
        imem_ready = 1'b1;
        addr_q.push_back(32'h0);
        push_instr(32'h0);
        tick(); tick();
        imem_ready = 1'b0;
        tick(); tick();

        chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
        chk("instr_q_drained", 32'(instr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
